led_scan_sequencer: RTL
=======================

Name: led_scan_sequencer

Overview:
Control sequencer for the registered 3-to-8 active-low LED decoder stage. It walks a programmable set of LED channels, presenting each on the decoder's switch/enable inputs for a programmable dwell time, in either one-shot or continuous-loop mode. It also outputs the decoded LED pattern directly for standalone use. It sits between the control/CSR logic (start/stop/mask/dwell) and the decoder.

Parameters:
DWELL_W, 8, width of dwell count; each channel is active for dwell+1 cycles.

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous reset, active-high
start  input  1  single-cycle request to begin a scan; ignored while busy
stop  input  1  single-cycle abort request; takes effect at next edge
mask  input  8  channel-select bitmap; sampled on accepted start
dwell  input  DWELL_W  dwell-1 per channel; sampled on accepted start
loop  input  1  0 = one pass, 1 = continuous; sampled on accepted start
switch  output  3  channel index to decoder
enable  output  3  decoder enable; 3'b100 = active, 3'b000 = idle
led  output  8  active-low decoded pattern, ~(1<<switch) when active, else 8'hFF
busy  output  1  high while scanning
done  output  1  one-cycle pulse on normal one-shot completion
wrap  output  1  one-cycle pulse when a continuous pass restarts at the first channel

Behaviour:
- Reset: asynchronous. Interface decided as: reset rst, asynchronous, active-high; clock clk. On reset: state IDLE, switch=0, enable=3'b000, led=8'hFF, busy=0, done=0, wrap=0. All latched config cleared to 0.
- All outputs are registered. switch, enable and led always change on the same edge and stay mutually consistent.
- States: IDLE, SCAN.
- IDLE: enable=000, led=FF, busy=0.
  - start=1, stop=0, mask!=0: latch mask/dwell/loop; cur = lowest set bit of mask; cnt=0; go to SCAN. Outputs reflect the first channel in the cycle after start.
  - start=1, mask==0: stay IDLE; done pulses the next cycle.
  - start and stop both high: stop wins; stay IDLE, no done.
- SCAN: enable=100, switch=cur, led=~(8'b1<<cur), busy=1. cnt increments each cycle.
  - When cnt==dwell_l and a set bit of mask_l exists above cur: cur=next-higher set bit, cnt=0.
  - When cnt==dwell_l and cur is the highest set bit, loop_l=1: cur=lowest set bit, cnt=0, wrap=1 for one cycle, coincident with the first-channel outputs.
  - When cnt==dwell_l and cur is the highest set bit, loop_l=0: go to IDLE; done=1 in the first IDLE cycle, same edge that enable returns to 000.
  - stop=1: go to IDLE at the next edge; done=0; wrap=0. Stop overrides dwell expiry in the same cycle.
  - start while in SCAN: ignored. mask/dwell/loop input changes are ignored until the next accepted start.
- Timing: dwell=0 gives 1 cycle per channel. dwell=all-ones gives 2^DWELL_W cycles. Single-bit mask with loop=1 keeps that channel lit continuously and pulses wrap every dwell+1 cycles.
- Channel search: next-higher set bit and lowest set bit are computed with a combinational priority search. There are no idle gaps between channels.
- Reset mid-scan: immediate return to reset values and no done pulse.

Test Plan:
- Reset mid-scan: mask=FF, dwell=3, loop=1, start; assert rst at cycle 5 -> led=FF, enable=000, busy=0 asynchronously; done and wrap never pulse.
- One-shot: mask=8'b0010_0101, dwell=2, loop=0, start at cycle 0 -> cycles 1-3 led=FE/switch=0; cycles 4-6 led=FB/switch=2; cycles 7-9 led=DF/switch=5; cycle 10 led=FF, enable=000, done=1; cycle 11 done=0.
- Continuous with wrap: mask=8'b1000_0010, dwell=0, loop=1 -> led alternates FD, 7F each cycle; wrap=1 on every FD cycle after the first; busy stays 1 until stop.
- Stop and start/stop collision: during SCAN assert stop -> next cycle enable=000, led=FF, done=0. In IDLE assert start and stop together -> remains IDLE, no done.
- Empty mask and ignored start: start with mask=0 -> busy stays 0, done pulses once. Start with new mask while busy -> sequence unchanged.
- Dwell boundary: DWELL_W=8, dwell=8'hFF, mask=01 -> channel 0 held exactly 256 cycles, then done.

Source files
------------

// File: rtl/led_scan_sequencer_if.sv
// rtl/led_scan_sequencer_if.sv - control/status bundle between CSR logic, scan sequencer and LED decoder
interface led_scan_sequencer_if #(
    parameter int DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic [7:0]         mask;
    logic [DWELL_W-1:0] dwell;
    logic               loop;
    logic [2:0]         switch;
    logic [2:0]         enable;
    logic [7:0]         led;
    logic               busy;
    logic               done;
    logic               wrap;

    modport master (
        output start, stop, mask, dwell, loop,
        input  switch, enable, led, busy, done, wrap
    );

    modport slave (
        input  start, stop, mask, dwell, loop,
        output switch, enable, led, busy, done, wrap
    );
endinterface

// File: rtl/led_scan_sequencer.sv
// rtl/led_scan_sequencer.sv - walks masked LED channels with programmable dwell, one-shot or looping
module led_scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    led_scan_sequencer_if.slave bus
);
    typedef enum logic [0:0] {IDLE, SCAN} state_t;

    state_t             state_q, state_d;
    logic [7:0]         mask_l_q, mask_l_d;
    logic [DWELL_W-1:0] dwell_l_q, dwell_l_d;
    logic               loop_l_q, loop_l_d;
    logic [2:0]         cur_q, cur_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;

    logic [2:0]         switch_q, switch_d;
    logic [2:0]         enable_q, enable_d;
    logic [7:0]         led_q, led_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               wrap_q, wrap_d;

    logic [7:0]         above_mask;
    logic               has_above;
    logic [2:0]         next_ch;
    logic [2:0]         first_latched;
    logic [2:0]         first_input;

    function automatic logic [2:0] lowest_bit(input logic [7:0] m);
        lowest_bit = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) lowest_bit = i[2:0];
        end
    endfunction

    // Channels strictly above the current one; an empty result means end of pass.
    always_comb begin
        above_mask    = mask_l_q & (8'hFE << cur_q);
        has_above     = |above_mask;
        next_ch       = lowest_bit(above_mask);
        first_latched = lowest_bit(mask_l_q);
        first_input   = lowest_bit(bus.mask);
    end

    always_comb begin
        state_d   = state_q;
        mask_l_d  = mask_l_q;
        dwell_l_d = dwell_l_q;
        loop_l_d  = loop_l_q;
        cur_d     = cur_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        wrap_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    if (bus.mask != 8'h00) begin
                        mask_l_d  = bus.mask;
                        dwell_l_d = bus.dwell;
                        loop_l_d  = bus.loop;
                        cur_d     = first_input;
                        cnt_d     = '0;
                        state_d   = SCAN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (cnt_q == dwell_l_q) begin
                    cnt_d = '0;
                    if (has_above) begin
                        cur_d = next_ch;
                    end else if (loop_l_q) begin
                        cur_d  = first_latched;
                        wrap_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Decoder-facing outputs are derived from the next state so all three move together.
        if (state_d == SCAN) begin
            switch_d = cur_d;
            enable_d = 3'b100;
            led_d    = ~(8'h01 << cur_d);
            busy_d   = 1'b1;
        end else begin
            switch_d = 3'd0;
            enable_d = 3'b000;
            led_d    = 8'hFF;
            busy_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mask_l_q  <= 8'h00;
            dwell_l_q <= '0;
            loop_l_q  <= 1'b0;
            cur_q     <= 3'd0;
            cnt_q     <= '0;
            switch_q  <= 3'd0;
            enable_q  <= 3'b000;
            led_q     <= 8'hFF;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_l_q  <= mask_l_d;
            dwell_l_q <= dwell_l_d;
            loop_l_q  <= loop_l_d;
            cur_q     <= cur_d;
            cnt_q     <= cnt_d;
            switch_q  <= switch_d;
            enable_q  <= enable_d;
            led_q     <= led_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wrap_q    <= wrap_d;
        end
    end

    assign bus.switch = switch_q;
    assign bus.enable = enable_q;
    assign bus.led    = led_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.wrap   = wrap_q;
endmodule
